instr_scheduler: RTL and testbench

- Sits between the SPI instruction deserializer and the shared memory/accelerator command bus.
- Accepts one decoded instruction {valid, opcode, key_addr, text_addr, dest_addr} at a time.
- Sequences the instruction as key load, text load, accelerator start, wait for completion, result store.
- Supervises every wait with a watchdog and reports completion or error.

---
 rtl/instr_sched_pkg.sv | 45 ++++
 rtl/sched_watchdog.sv | 32 +++
 rtl/instr_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_instr_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sched_pkg.sv
// Shared definitions for the instruction scheduler: FSM state encoding,
// opcode map, bus command codes, error codes and accelerator indices.
package instr_sched_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DISCARD,
        S_LD_KEY,
        S_WAIT_KEY,
        S_LD_TEXT,
        S_WAIT_TEXT,
        S_START,
        S_RUN,
        S_ST,
        S_WAIT_ST
    } state_t;

    // Instruction opcodes
    localparam logic [1:0] OP_AES_ENC = 2'b00;
    localparam logic [1:0] OP_AES_DEC = 2'b01;
    localparam logic [1:0] OP_SHA     = 2'b10;
    localparam logic [1:0] OP_RSVD    = 2'b11;

    // Bus command codes
    localparam logic [1:0] CMD_LOAD_KEY  = 2'b00;
    localparam logic [1:0] CMD_LOAD_TEXT = 2'b01;
    localparam logic [1:0] CMD_STORE     = 2'b10;

    // Error codes
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BAD_OP  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_BAD_PKT = 2'b11;

    // Accelerator indices (cmd_sel value, accel_start/accel_done bit)
    localparam logic ACC_AES = 1'b0;
    localparam logic ACC_SHA = 1'b1;

    // States in which the watchdog supervises an external event
    function automatic logic is_wait(state_t s);
        return (s == S_WAIT_KEY) || (s == S_WAIT_TEXT) ||
               (s == S_RUN)      || (s == S_WAIT_ST);
    endfunction

endpackage

// File: rtl/sched_watchdog.sv
// Watchdog counter for the scheduler's wait states.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - force the count to zero (held while not waiting)
//   en        - count one waiting cycle
//   expired   - high in the (2^TMO_W-1)-th consecutive waiting cycle
module sched_watchdog #(
    parameter int TMO_W = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // The first waiting cycle sees count 0, so the (2^TMO_W-1)-th one
    // sees 2^TMO_W-2.
    localparam logic [TMO_W-1:0] LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/instr_scheduler.sv
// Instruction scheduler: takes one decoded instruction at a time and drives
// key load, text load, accelerator start, completion wait and result store
// over the shared command bus, with every wait supervised by a watchdog.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   in_valid / in_ready          - instruction handshake with the deserializer
//   in_pkt_valid, in_opcode,
//   in_key_addr, in_text_addr,
//   in_dest_addr                 - instruction fields, captured on transfer
//   cmd_valid / cmd_ready        - bus command handshake
//   cmd_op, cmd_addr, cmd_sel    - command code, address, target accelerator
//   xfer_done                    - pulse: accepted bus transfer finished
//   accel_start, accel_mode      - one-hot start pulse, AES direction
//   accel_done                   - one-hot completion pulse
//   busy, done, err, err_code    - status
module instr_scheduler
    import instr_sched_pkg::*;
#(
    parameter int ADDRW   = 8,
    parameter int OPCODEW = 2,
    parameter int TMO_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_pkt_valid,
    input  logic [OPCODEW-1:0] in_opcode,
    input  logic [ADDRW-1:0]   in_key_addr,
    input  logic [ADDRW-1:0]   in_text_addr,
    input  logic [ADDRW-1:0]   in_dest_addr,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [1:0]         cmd_op,
    output logic [ADDRW-1:0]   cmd_addr,
    output logic               cmd_sel,
    input  logic               xfer_done,
    output logic [1:0]         accel_start,
    output logic               accel_mode,
    input  logic [1:0]         accel_done,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code
);

    state_t           state, state_n;
    logic [ADDRW-1:0] key_q, text_q, dest_q;
    logic             sel_q, mode_q;
    logic             capture;
    logic             done_n, err_n;
    logic [1:0]       code_n;
    logic             waiting, expired;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign cmd_sel  = sel_q;
    assign accel_mode = mode_q;
    assign waiting  = is_wait(state);

    // Held clear outside the wait states, so every wait entry starts at 0.
    sched_watchdog #(.TMO_W(TMO_W)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!waiting),
        .en      (waiting),
        .expired (expired)
    );

    always_comb begin
        state_n     = state;
        capture     = 1'b0;
        done_n      = 1'b0;
        err_n       = 1'b0;
        code_n      = err_code;
        cmd_valid   = 1'b0;
        cmd_op      = CMD_LOAD_KEY;
        cmd_addr    = key_q;
        accel_start = 2'b00;

        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    if (!in_pkt_valid) begin
                        state_n = S_DISCARD;
                        err_n   = 1'b1;
                        code_n  = ERR_BAD_PKT;
                    end else if (in_opcode == OPCODEW'(OP_RSVD)) begin
                        state_n = S_DISCARD;
                        err_n   = 1'b1;
                        code_n  = ERR_BAD_OP;
                    end else if (in_opcode == OPCODEW'(OP_SHA)) begin
                        state_n = S_LD_TEXT;
                    end else begin
                        state_n = S_LD_KEY;
                    end
                end
            end
            // err was registered on the capture edge and is visible here
            S_DISCARD: state_n = S_IDLE;
            S_LD_KEY: begin
                cmd_valid = 1'b1;
                cmd_op    = CMD_LOAD_KEY;
                cmd_addr  = key_q;
                if (cmd_ready) state_n = S_WAIT_KEY;
            end
            S_WAIT_KEY: begin
                if (xfer_done) begin
                    state_n = S_LD_TEXT;
                end else if (expired) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                end
            end
            S_LD_TEXT: begin
                cmd_valid = 1'b1;
                cmd_op    = CMD_LOAD_TEXT;
                cmd_addr  = text_q;
                if (cmd_ready) state_n = S_WAIT_TEXT;
            end
            S_WAIT_TEXT: begin
                if (xfer_done) begin
                    state_n = S_START;
                end else if (expired) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                end
            end
            S_START: begin
                accel_start = (sel_q == ACC_SHA) ? 2'b10 : 2'b01;
                state_n     = S_RUN;
            end
            S_RUN: begin
                // Only the selected accelerator's done bit counts
                if (accel_done[sel_q]) begin
                    state_n = S_ST;
                end else if (expired) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                end
            end
            S_ST: begin
                cmd_valid = 1'b1;
                cmd_op    = CMD_STORE;
                cmd_addr  = dest_q;
                if (cmd_ready) state_n = S_WAIT_ST;
            end
            S_WAIT_ST: begin
                if (xfer_done) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else if (expired) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            key_q    <= '0;
            text_q   <= '0;
            dest_q   <= '0;
            sel_q    <= 1'b0;
            mode_q   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_n;
            done     <= done_n;
            err      <= err_n;
            err_code <= code_n;
            if (capture) begin
                key_q  <= in_key_addr;
                text_q <= in_text_addr;
                dest_q <= in_dest_addr;
                sel_q  <= (in_opcode == OPCODEW'(OP_SHA));
                mode_q <= (in_opcode == OPCODEW'(OP_AES_DEC));
            end
        end
    end

endmodule

// File: tb/tb_instr_scheduler.sv
// Self-checking bench for instr_scheduler (TMO_W=4: timeout after 15 waiting
// cycles). A reactive bus/accelerator responder runs each instruction with
// chosen backpressure and response delays; results are compared against a
// table of hand-computed outcomes and a transaction-level reference model.
module tb_instr_scheduler;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_ready, in_pkt_valid = 1'b0;
    logic [1:0] in_opcode = '0;
    logic [7:0] in_key_addr = '0, in_text_addr = '0, in_dest_addr = '0;
    logic       cmd_valid, cmd_ready = 1'b0, cmd_sel;
    logic [1:0] cmd_op;
    logic [7:0] cmd_addr;
    logic       xfer_done = 1'b0;
    logic [1:0] accel_start, accel_done = '0;
    logic       accel_mode, busy, done, err;
    logic [1:0] err_code;

    instr_scheduler #(.ADDRW(8), .OPCODEW(2), .TMO_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pkt_valid(in_pkt_valid),
        .in_opcode(in_opcode), .in_key_addr(in_key_addr),
        .in_text_addr(in_text_addr), .in_dest_addr(in_dest_addr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_sel(cmd_sel), .xfer_done(xfer_done),
        .accel_start(accel_start), .accel_mode(accel_mode),
        .accel_done(accel_done), .busy(busy), .done(done), .err(err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         pv;
        logic [1:0] op;
        logic [7:0] key, text, dest;
        int         bp, xd, ad;     // backpressure per command, xfer delay, accel delay
        bit         exp_done;
        logic [1:0] exp_code;
        int         exp_lat;        // cycles from capture edge to done/err cycle
    } vec_t;

    typedef struct {
        int              ncmd;
        logic [2:0][1:0] cop;
        logic [2:0][7:0] cad;
        bit              sel;
        int              nstart;
        bit              is_done;
        logic [1:0]      code;
        int              lat;
        bit              rdy;
        bit              disc;
    } exp_t;

    function automatic vec_t mk(bit pv, logic [1:0] op, logic [7:0] k, logic [7:0] t,
                                logic [7:0] d, int bp, int xd, int ad,
                                bit ed, logic [1:0] ec, int el);
        vec_t v;
        v.pv = pv; v.op = op; v.key = k; v.text = t; v.dest = d;
        v.bp = bp; v.xd = xd; v.ad = ad;
        v.exp_done = ed; v.exp_code = ec; v.exp_lat = el;
        return v;
    endfunction

    // Transaction-level expectation: phase list with cycle costs.
    function automatic exp_t model(vec_t v);
        exp_t e;
        bit to = 0;
        logic [1:0] ops[$];
        logic [7:0] ads[$];
        e.ncmd = 0; e.cop = '0; e.cad = '0; e.nstart = 0; e.lat = 0;
        e.is_done = 0; e.code = 2'b00; e.rdy = 1; e.disc = 0;
        e.sel = (v.op == 2'b10);
        if (!v.pv || v.op == 2'b11) begin
            e.disc = 1; e.code = !v.pv ? 2'b11 : 2'b01; e.lat = 1; e.rdy = 0;
            return e;
        end
        if (!e.sel) begin ops.push_back(2'b00); ads.push_back(v.key); end
        ops.push_back(2'b01); ads.push_back(v.text);
        foreach (ops[i]) if (!to) begin
            e.cop[e.ncmd] = ops[i]; e.cad[e.ncmd] = ads[i]; e.ncmd++;
            e.lat += v.bp + 1;
            if (v.xd >= TMO) begin e.lat += TMO; to = 1; end
            else e.lat += v.xd + 1;
        end
        if (!to) begin
            e.nstart = 1; e.lat += 1;
            if (v.ad >= TMO) begin e.lat += TMO; to = 1; end
            else e.lat += v.ad + 1;
        end
        if (!to) begin
            e.cop[e.ncmd] = 2'b10; e.cad[e.ncmd] = v.dest; e.ncmd++;
            e.lat += v.bp + 1;
            if (v.xd >= TMO) begin e.lat += TMO; to = 1; end
            else e.lat += v.xd + 1;
        end
        e.is_done = !to;
        e.code = to ? 2'b10 : 2'b00;
        e.lat += 1;
        return e;
    endfunction

    logic [1:0] last_code = 2'b00;
    bit         prev_disc = 0;

    task automatic run(input vec_t v, input bit use_tbl, input string tag);
        exp_t       e;
        int         cyc, wait_c, bpl, px, pa, nstart, ncmd;
        bit         in_cmd, unstable, busy_bad, got, exp_done;
        logic [1:0] rop[8];
        logic [7:0] rad[8];
        logic       rsel[8];
        logic [1:0] sval, ecode;
        logic       smode, o_done, o_err, o_rdy;
        logic [1:0] o_code;
        e = model(v);
        px = -1; pa = -1; nstart = 0; ncmd = 0; in_cmd = 0; bpl = 0;
        unstable = 0; busy_bad = 0; got = 0; sval = 2'b00; smode = 0;
        o_done = 0; o_err = 0; o_rdy = 0; o_code = 0;
        in_valid = 1; in_pkt_valid = v.pv; in_opcode = v.op;
        in_key_addr = v.key; in_text_addr = v.text; in_dest_addr = v.dest;
        wait_c = 0;
        while (!in_ready && wait_c < 20) begin @(negedge clk); wait_c++; end
        chk($sformatf("%s idle_wait", tag), wait_c, prev_disc ? 1 : 0);
        @(posedge clk);
        @(negedge clk);
        // Scramble the inputs: the instruction must come from holding registers
        in_valid = 0; in_pkt_valid = $urandom; in_opcode = $urandom;
        in_key_addr = $urandom; in_text_addr = $urandom; in_dest_addr = $urandom;
        cyc = 1;
        while (!got && cyc < 400) begin
            if (done || err) begin
                got = 1; o_done = done; o_err = err; o_code = err_code; o_rdy = in_ready;
            end else begin
                if (in_ready || !busy) busy_bad = 1;
                xfer_done = 0; accel_done = 2'b00; cmd_ready = 0;
                if (px == 0) xfer_done = 1;
                if (px >= 0) px--;
                if (pa >= 0) begin
                    if (pa == 0) accel_done = sval;
                    else if (pa == v.ad && v.ad > 1) accel_done = ~sval;  // wrong accelerator
                    pa--;
                end
                if (accel_start != 2'b00) begin
                    nstart++; sval = accel_start; smode = accel_mode; pa = v.ad;
                end
                if (cmd_valid) begin
                    if (!in_cmd) begin
                        if (ncmd < 8) begin rop[ncmd] = cmd_op; rad[ncmd] = cmd_addr; rsel[ncmd] = cmd_sel; end
                        ncmd++; in_cmd = 1; bpl = v.bp;
                    end else if (ncmd <= 8) begin
                        if (cmd_op !== rop[ncmd-1] || cmd_addr !== rad[ncmd-1] ||
                            cmd_sel !== rsel[ncmd-1]) unstable = 1;
                    end
                    if (bpl > 0) begin
                        bpl--;
                        if (bpl[0]) xfer_done = 1;   // stray pulse outside a wait state
                    end else begin
                        cmd_ready = 1; in_cmd = 0; px = v.xd;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        xfer_done = 0; accel_done = 2'b00; cmd_ready = 0;
        exp_done = use_tbl ? v.exp_done : e.is_done;
        if (!exp_done) begin
            ecode = use_tbl ? v.exp_code : e.code;
            last_code = ecode;
        end
        chk($sformatf("%s outcome_seen", tag), got, 1);
        chk($sformatf("%s latency", tag), cyc, use_tbl ? v.exp_lat : e.lat);
        chk($sformatf("%s done", tag), o_done, exp_done);
        chk($sformatf("%s err", tag), o_err, !exp_done);
        chk($sformatf("%s err_code", tag), o_code, last_code);
        chk($sformatf("%s in_ready_at_end", tag), o_rdy, e.rdy);
        chk($sformatf("%s busy_window", tag), busy_bad, 0);
        chk($sformatf("%s cmd_stable", tag), unstable, 0);
        chk($sformatf("%s ncmd", tag), ncmd, e.ncmd);
        for (int i = 0; i < 3; i++) begin
            if (i < ncmd && i < e.ncmd) begin
                chk($sformatf("%s cmd%0d_op", tag, i), rop[i], e.cop[i]);
                chk($sformatf("%s cmd%0d_addr", tag, i), rad[i], e.cad[i]);
                chk($sformatf("%s cmd%0d_sel", tag, i), rsel[i], e.sel);
            end
        end
        chk($sformatf("%s nstart", tag), nstart, e.nstart);
        if (nstart == 1 && e.nstart == 1) begin
            chk($sformatf("%s start_val", tag), sval, e.sel ? 2'b10 : 2'b01);
            if (!e.sel) chk($sformatf("%s mode", tag), smode, v.op[0]);
        end
        prev_disc = e.disc;
    endtask

    vec_t tbl[11];
    vec_t rv;
    int   k;

    initial begin
        tbl[0]  = mk(1, 2'b00, 8'hAA, 8'h55, 8'h0E,  0,  3, 12, 1, 2'b00, 30);
        tbl[1]  = mk(1, 2'b10, 8'h0F, 8'hF0, 8'h7C,  0,  3, 12, 1, 2'b00, 25);
        tbl[2]  = mk(0, 2'b01, 8'h12, 8'h34, 8'h56,  0,  0,  0, 0, 2'b11,  1);
        tbl[3]  = mk(1, 2'b11, 8'h12, 8'h34, 8'h56,  0,  0,  0, 0, 2'b01,  1);
        tbl[4]  = mk(1, 2'b01, 8'hAA, 8'h21, 8'h43, 50,  0,  0, 1, 2'b00, 159);
        tbl[5]  = mk(1, 2'b00, 8'h01, 8'h02, 8'h03,  0,  0,  0, 1, 2'b00,  9);
        tbl[6]  = mk(1, 2'b00, 8'h10, 8'h20, 8'h30,  0,  0, 14, 1, 2'b00, 23);
        tbl[7]  = mk(1, 2'b00, 8'h11, 8'h22, 8'h33,  0,  0, 15, 0, 2'b10, 21);
        tbl[8]  = mk(1, 2'b10, 8'h44, 8'h55, 8'h66,  0, 14,  0, 1, 2'b00, 35);
        tbl[9]  = mk(1, 2'b01, 8'h77, 8'h88, 8'h99,  0, 15,  0, 0, 2'b10, 17);
        tbl[10] = mk(1, 2'b10, 8'hC1, 8'hC2, 8'hC3,  0,  0,  0, 1, 2'b00,  7);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst in_ready", in_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst cmd_valid", cmd_valid, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst err_code", err_code, 0);
        chk("rst accel_start", accel_start, 0);
        chk("rst accel_mode", accel_mode, 0);
        chk("rst cmd_sel", cmd_sel, 0);
        rst = 0;
        @(negedge clk);

        foreach (tbl[i]) run(tbl[i], 1, $sformatf("tbl%0d", i));

        // Reset during RUN with a second instruction pending
        in_valid = 1; in_pkt_valid = 1; in_opcode = 2'b00;
        in_key_addr = 8'h11; in_text_addr = 8'h22; in_dest_addr = 8'h33;
        cmd_ready = 1; xfer_done = 1; accel_done = 2'b00;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        k = 0;
        while (accel_start == 2'b00 && k < 20) begin @(negedge clk); k++; end
        chk("rs start_seen", accel_start, 2'b01);
        @(negedge clk);
        in_valid = 1; in_opcode = 2'b01;
        in_key_addr = 8'h44; in_text_addr = 8'h55; in_dest_addr = 8'h66;
        for (int i = 0; i < 3; i++) begin
            chk("rs held_not_ready", in_ready, 0);
            chk("rs no_cmd_in_run", cmd_valid, 0);
            @(negedge clk);
        end
        rst = 1;
        @(negedge clk);
        chk("rs post in_ready", in_ready, 1);
        chk("rs post busy", busy, 0);
        chk("rs post done", done, 0);
        chk("rs post err", err, 0);
        chk("rs post err_code", err_code, 0);
        chk("rs post cmd_valid", cmd_valid, 0);
        chk("rs post accel_start", accel_start, 0);
        rst = 0;
        @(negedge clk);
        chk("rs recapture cmd_valid", cmd_valid, 1);
        chk("rs recapture cmd_op", cmd_op, 2'b00);
        chk("rs recapture cmd_addr", cmd_addr, 8'h44);
        in_valid = 0;
        accel_done = 2'b01;
        k = 0;
        while (!(done || err) && k < 40) begin @(negedge clk); k++; end
        chk("rs finish done", done, 1);
        chk("rs finish err", err, 0);
        cmd_ready = 0; xfer_done = 0; accel_done = 2'b00;
        last_code = 2'b00; prev_disc = 0;

        // Randomized instructions against the reference model
        for (int i = 0; i < 40; i++) begin
            rv.pv   = ($urandom % 8) != 0;
            rv.op   = $urandom;
            rv.key  = $urandom; rv.text = $urandom; rv.dest = $urandom;
            rv.bp   = $urandom % 4;
            rv.xd   = ($urandom % 6 == 0) ? 13 + ($urandom % 4) : ($urandom % 4);
            rv.ad   = ($urandom % 5 == 0) ? 12 + ($urandom % 5) : ($urandom % 6);
            rv.exp_done = 0; rv.exp_code = 0; rv.exp_lat = 0;
            run(rv, 0, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
